map_scan_classifier: RTL

- Streams one complete map frame, cell by cell, over a valid/ready handshake.
- Classifies each cell as start, goal, wall or visited, and latches the start and goal positions.
- Counts walls and visited cells, and flags duplicate or missing markers.
- Parametrised successor to the single-cell search classifier. Feeds the bidirectional-search engine with seed positions and a map-valid verdict before expansion begins.

---
 rtl/map_scan_classifier.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/map_scan_classifier.sv
// Streams one map frame cell by cell, classifies each cell, latches the first
// start/goal positions and reports wall/visited counts plus a map-valid verdict.
module map_scan_classifier #(
   parameter int unsigned       CELL_W     = 8,
   parameter int unsigned       IDX_W      = 8,
   parameter int unsigned       MAP_CELLS  = 256,
   parameter logic [CELL_W-1:0] START_CODE = CELL_W'(8'h7F),
   parameter logic [CELL_W-1:0] GOAL_CODE  = CELL_W'(8'h00)
) (
   input  logic              m_clock,
   input  logic              p_reset,
   input  logic              scan_go,
   input  logic              scan_abort,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CELL_W-1:0] cell_in,
   output logic              busy,
   output logic              done,
   output logic [IDX_W-1:0]  cell_idx,
   output logic [CELL_W-1:0] data_out,
   output logic [IDX_W-1:0]  start_pos,
   output logic [IDX_W-1:0]  goal_pos,
   output logic              start_found,
   output logic              goal_found,
   output logic              dup_error,
   output logic              map_ok,
   output logic [IDX_W:0]    wall_count,
   output logic [IDX_W:0]    visit_count
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SCAN    = 2'd1,
      DONE_ST = 2'd2
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAP_CELLS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
   localparam logic [IDX_W:0]   CNT_ONE  = {{IDX_W{1'b0}}, 1'b1};

   state_t              state_r;
   logic                in_ready_r;
   logic                busy_r;
   logic                done_r;
   logic [IDX_W-1:0]    cell_idx_r;
   logic [CELL_W-1:0]   data_out_r;
   logic [IDX_W-1:0]    start_pos_r;
   logic [IDX_W-1:0]    goal_pos_r;
   logic                start_found_r;
   logic                goal_found_r;
   logic                dup_error_r;
   logic                map_ok_r;
   logic [IDX_W:0]      wall_count_r;
   logic [IDX_W:0]      visit_count_r;

   logic                accept_s;
   logic                last_s;
   logic                is_start_s;
   logic                is_goal_s;
   logic                is_wall_s;
   logic                is_visit_s;
   logic [IDX_W-1:0]    start_pos_n_s;
   logic [IDX_W-1:0]    goal_pos_n_s;
   logic                start_found_n_s;
   logic                goal_found_n_s;
   logic                dup_error_n_s;
   logic [IDX_W:0]      wall_count_n_s;
   logic [IDX_W:0]      visit_count_n_s;

   // Priority classification of the offered cell and the resulting next flag/count values
   always_comb begin
      accept_s        = in_valid & in_ready_r;
      last_s          = (cell_idx_r == LAST_IDX);
      is_start_s      = (cell_in == START_CODE);
      is_goal_s       = (cell_in == GOAL_CODE) & ~is_start_s;
      is_wall_s       = cell_in[CELL_W-1] & ~is_start_s & ~is_goal_s;
      is_visit_s      = (cell_in[CELL_W-2 -: 2] == 2'b10) & ~is_start_s & ~is_goal_s & ~is_wall_s;
      start_pos_n_s   = start_pos_r;
      goal_pos_n_s    = goal_pos_r;
      start_found_n_s = start_found_r;
      goal_found_n_s  = goal_found_r;
      dup_error_n_s   = dup_error_r;
      if (is_start_s) begin
         if (start_found_r) begin
            dup_error_n_s = 1'b1;
         end else begin
            start_found_n_s = 1'b1;
            start_pos_n_s   = cell_idx_r;
         end
      end else begin
         start_found_n_s = start_found_r;
      end
      if (is_goal_s) begin
         if (goal_found_r) begin
            dup_error_n_s = 1'b1;
         end else begin
            goal_found_n_s = 1'b1;
            goal_pos_n_s   = cell_idx_r;
         end
      end else begin
         goal_found_n_s = goal_found_r;
      end
      if (is_wall_s) begin
         wall_count_n_s = wall_count_r + CNT_ONE;
      end else begin
         wall_count_n_s = wall_count_r;
      end
      if (is_visit_s) begin
         visit_count_n_s = visit_count_r + CNT_ONE;
      end else begin
         visit_count_n_s = visit_count_r;
      end
   end

   // Scan FSM; every output is a register updated here
   always_ff @(posedge m_clock) begin
      if (!p_reset) begin
         state_r       <= IDLE;
         in_ready_r    <= 1'b0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         cell_idx_r    <= '0;
         data_out_r    <= '0;
         start_pos_r   <= '0;
         goal_pos_r    <= '0;
         start_found_r <= 1'b0;
         goal_found_r  <= 1'b0;
         dup_error_r   <= 1'b0;
         map_ok_r      <= 1'b0;
         wall_count_r  <= '0;
         visit_count_r <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (scan_go) begin
                  state_r       <= SCAN;
                  in_ready_r    <= 1'b1;
                  busy_r        <= 1'b1;
                  cell_idx_r    <= '0;
                  start_found_r <= 1'b0;
                  goal_found_r  <= 1'b0;
                  dup_error_r   <= 1'b0;
                  map_ok_r      <= 1'b0;
                  wall_count_r  <= '0;
                  visit_count_r <= '0;
               end
            end
            SCAN: begin
               // Abort wins over a same-cycle acceptance; partial results are kept
               if (scan_abort) begin
                  state_r    <= IDLE;
                  in_ready_r <= 1'b0;
                  busy_r     <= 1'b0;
               end else if (accept_s) begin
                  data_out_r    <= cell_in;
                  start_pos_r   <= start_pos_n_s;
                  goal_pos_r    <= goal_pos_n_s;
                  start_found_r <= start_found_n_s;
                  goal_found_r  <= goal_found_n_s;
                  dup_error_r   <= dup_error_n_s;
                  wall_count_r  <= wall_count_n_s;
                  visit_count_r <= visit_count_n_s;
                  if (last_s) begin
                     state_r    <= DONE_ST;
                     in_ready_r <= 1'b0;
                     busy_r     <= 1'b0;
                     done_r     <= 1'b1;
                     cell_idx_r <= '0;
                     map_ok_r   <= start_found_n_s & goal_found_n_s & ~dup_error_n_s;
                  end else begin
                     cell_idx_r <= cell_idx_r + IDX_ONE;
                  end
               end
            end
            DONE_ST: begin
               state_r <= IDLE;
               done_r  <= 1'b0;
            end
            default: begin
               state_r    <= IDLE;
               in_ready_r <= 1'b0;
               busy_r     <= 1'b0;
               done_r     <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_r;
   assign busy        = busy_r;
   assign done        = done_r;
   assign cell_idx    = cell_idx_r;
   assign data_out    = data_out_r;
   assign start_pos   = start_pos_r;
   assign goal_pos    = goal_pos_r;
   assign start_found = start_found_r;
   assign goal_found  = goal_found_r;
   assign dup_error   = dup_error_r;
   assign map_ok      = map_ok_r;
   assign wall_count  = wall_count_r;
   assign visit_count = visit_count_r;

endmodule
